// File: rtl/icache_2way_param.sv
// icache_2way_param: 2-way set-associative read-only instruction cache with LRU, flush and hit/miss counters
module icache_2way_param #(
    parameter int INDEX_BITS  = 3,
    parameter int OFFSET_BITS = 2,
    parameter int TAG_BITS    = 3,
    parameter int CNT_W       = 16
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [31:0]                         PC,
    input  logic                                flush,
    output logic [31:0]                         INSTRUCTION,
    output logic                                BUSYWAIT_INSTR,
    output logic                                instr_read,
    output logic [TAG_BITS+INDEX_BITS-1:0]      instr_address,
    input  logic [(32<<OFFSET_BITS)-1:0]        instr_readdata,
    input  logic                                instr_busywait,
    output logic [CNT_W-1:0]                    hit_count,
    output logic [CNT_W-1:0]                    miss_count
);
    localparam int SETS  = 1 << INDEX_BITS;
    localparam int BLK_W = 32 << OFFSET_BITS;
    localparam int AW    = TAG_BITS + INDEX_BITS;
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] MEM_READ = 1'b1;

    logic [0:0]            state;
    logic [SETS-1:0]       valid0, valid1, lru;
    logic [TAG_BITS-1:0]   tag0 [SETS];
    logic [TAG_BITS-1:0]   tag1 [SETS];
    logic [BLK_W-1:0]      data0 [SETS];
    logic [BLK_W-1:0]      data1 [SETS];
    logic [TAG_BITS-1:0]   pc_tag, fill_tag;
    logic [INDEX_BITS-1:0] pc_index, fill_index;
    logic [OFFSET_BITS-1:0] pc_offset;
    logic                  fill_way, flush_pending, refill_done;
    logic                  hit0, hit1, hit, victim, fill_done;
    logic                  unused_pc;

    assign pc_offset = PC[OFFSET_BITS+1:2];
    assign pc_index  = PC[OFFSET_BITS+2 +: INDEX_BITS];
    assign pc_tag    = PC[OFFSET_BITS+INDEX_BITS+2 +: TAG_BITS];
    assign unused_pc = ^{PC[31:AW+OFFSET_BITS+2], PC[1:0]};

    assign hit0 = valid0[pc_index] && tag0[pc_index] == pc_tag;
    assign hit1 = valid1[pc_index] && tag1[pc_index] == pc_tag;
    assign hit  = hit0 || hit1;

    // Victim prefers an empty way before consulting the LRU bit
    assign victim    = !valid0[pc_index] ? 1'b0 : !valid1[pc_index] ? 1'b1 : lru[pc_index];
    assign fill_done = state == MEM_READ && !instr_busywait;

    assign INSTRUCTION    = hit0 ? data0[pc_index][{pc_offset, 5'd0} +: 32] :
                            hit1 ? data1[pc_index][{pc_offset, 5'd0} +: 32] : 32'd0;
    assign BUSYWAIT_INSTR = reset || state == MEM_READ || !hit || flush;
    assign instr_read     = state == MEM_READ;
    assign instr_address  = instr_read ? {fill_tag, fill_index} : '0;

    // Control state: FSM, valid/LRU bits, pending flush and saturating counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            valid0        <= '0;
            valid1        <= '0;
            lru           <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
            flush_pending <= 1'b0;
            refill_done   <= 1'b0;
            fill_tag      <= '0;
            fill_index    <= '0;
            fill_way      <= 1'b0;
        end else if (state == IDLE) begin
            refill_done <= 1'b0;
            if (flush) begin
                valid0 <= '0;
                valid1 <= '0;
            end else if (hit) begin
                lru[pc_index] <= hit0;
                if (!refill_done)
                    hit_count <= hit_count + {{(CNT_W-1){1'b0}}, ~&hit_count};
            end else begin
                fill_tag   <= pc_tag;
                fill_index <= pc_index;
                fill_way   <= victim;
                miss_count <= miss_count + {{(CNT_W-1){1'b0}}, ~&miss_count};
                state      <= MEM_READ;
            end
        end else if (!instr_busywait) begin
            if (flush || flush_pending) begin
                valid0 <= '0;
                valid1 <= '0;
            end else if (fill_way) begin
                valid1[fill_index] <= 1'b1;
            end else begin
                valid0[fill_index] <= 1'b1;
            end
            lru[fill_index] <= ~fill_way;
            refill_done     <= 1'b1;
            flush_pending   <= 1'b0;
            state           <= IDLE;
        end else if (flush) begin
            flush_pending <= 1'b1;
        end
    end

    // Line storage written only when a refill completes; a reset mid-fill leaves it untouched
    always_ff @(posedge clock) begin
        if (fill_done) begin
            if (fill_way) begin
                tag1[fill_index]  <= fill_tag;
                data1[fill_index] <= instr_readdata;
            end else begin
                tag0[fill_index]  <= fill_tag;
                data0[fill_index] <= instr_readdata;
            end
        end
    end
endmodule

// File: tb/tb_icache_2way_param.sv
// tb_icache_2way_param: directed fetch sequences checked against a recency-list cache model
module tb_icache_2way_param;
    localparam int LAT = 5;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         flush = 1'b0;
    logic [31:0]  PC = 32'd0;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT_INSTR, instr_read, instr_busywait;
    logic [5:0]   instr_address;
    logic [127:0] instr_readdata;
    logic [15:0]  hit_count, miss_count;
    int           checks = 0;
    int           errors = 0;
    int           mem_cnt = 0;

    icache_2way_param dut (
        .clock(clock), .reset(reset), .PC(PC), .flush(flush),
        .INSTRUCTION(INSTRUCTION), .BUSYWAIT_INSTR(BUSYWAIT_INSTR),
        .instr_read(instr_read), .instr_address(instr_address),
        .instr_readdata(instr_readdata), .instr_busywait(instr_busywait),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] word_of(input logic [7:0] wa);
        return {16'hA5C3, 8'h00, wa};
    endfunction

    // Instruction memory: block words derived from word address, ready on the LAT-th read cycle
    always_comb begin
        instr_readdata = '0;
        for (int w = 0; w < 4; w++) instr_readdata[w*32 +: 32] = word_of({instr_address, 2'(w)});
    end
    assign instr_busywait = !(instr_read && mem_cnt == LAT - 1);
    always @(posedge clock or posedge reset) mem_cnt <= (reset || !instr_read) ? 0 : mem_cnt + 1;

    // Model: per set an MRU/LRU tag list, plus a fill in progress
    int         res_n [8] = '{default: 0};
    logic [2:0] res_mru [8];
    logic [2:0] res_lru [8];
    bit         m_fill = 0, m_pend = 0, m_skip = 0;
    int         m_fcnt = 0, m_hits = 0, m_misses = 0;
    logic [5:0] m_addr = 6'd0;

    function automatic bit resident(input logic [31:0] pc);
        return (res_n[pc[6:4]] >= 1 && res_mru[pc[6:4]] == pc[9:7]) ||
               (res_n[pc[6:4]] == 2 && res_lru[pc[6:4]] == pc[9:7]);
    endfunction

    task automatic clear_all();
        for (int s = 0; s < 8; s++) res_n[s] = 0;
    endtask

    always @(posedge clock or posedge reset) begin
        bit skip_now;
        if (reset) begin
            clear_all();
            m_fill = 0; m_pend = 0; m_skip = 0; m_fcnt = 0; m_hits = 0; m_misses = 0;
        end else if (!m_fill) begin
            skip_now = m_skip;
            m_skip = 0;
            if (flush) clear_all();
            else if (resident(PC)) begin
                if (res_n[PC[6:4]] == 2 && res_lru[PC[6:4]] == PC[9:7]) begin
                    res_lru[PC[6:4]] = res_mru[PC[6:4]];
                    res_mru[PC[6:4]] = PC[9:7];
                end
                if (!skip_now && m_hits < 65535) m_hits++;
            end else begin
                if (m_misses < 65535) m_misses++;
                m_fill = 1; m_fcnt = 0; m_addr = PC[9:4];
            end
        end else begin
            m_fcnt++;
            m_pend = m_pend || flush;
            if (m_fcnt == LAT) begin
                if (m_pend) clear_all();
                else begin
                    if (res_n[m_addr[2:0]] > 0) res_lru[m_addr[2:0]] = res_mru[m_addr[2:0]];
                    res_mru[m_addr[2:0]] = m_addr[5:3];
                    if (res_n[m_addr[2:0]] < 2) res_n[m_addr[2:0]]++;
                end
                m_fill = 0; m_pend = 0; m_skip = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Every cycle: DUT outputs against the model
    always @(negedge clock) begin
        if (reset) begin
            chk("rst_busy", 32'(BUSYWAIT_INSTR), 32'd1);
            chk("rst_read", 32'(instr_read), 32'd0);
            chk("rst_hits", 32'(hit_count), 32'd0);
            chk("rst_miss", 32'(miss_count), 32'd0);
        end else begin
            chk("busy", 32'(BUSYWAIT_INSTR), 32'(m_fill || flush || !resident(PC)));
            chk("read", 32'(instr_read), 32'(m_fill));
            chk("addr", 32'(instr_address), m_fill ? 32'(m_addr) : 32'd0);
            chk("hits", 32'(hit_count), 32'(m_hits));
            chk("miss", 32'(miss_count), 32'(m_misses));
            if (!BUSYWAIT_INSTR) chk("instr", INSTRUCTION, word_of(PC[9:2]));
        end
    end

    task automatic fetch(input logic [31:0] pc, output int stalls, output logic [31:0] ins);
        bit done = 0;
        PC = pc;
        stalls = 0;
        ins = 32'd0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clock);
            if (!BUSYWAIT_INSTR) begin
                done = 1;
                ins = INSTRUCTION;
            end else stalls++;
        end
        chk("fetch_done", 32'(done), 32'd1);
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
    endtask

    int          st;
    logic [31:0] ins;
    logic [31:0] t3_pc [6] = '{32'h000, 32'h080, 32'h000, 32'h100, 32'h000, 32'h080};
    int          t3_st [6] = '{6, 6, 0, 6, 0, 6};

    initial begin
        #1 do_reset();
        fetch(32'h000, st, ins);
        chk("t1_stalls", 32'(st), 32'd6);
        chk("t1_word", ins, 32'hA5C30000);
        chk("t1_miss", 32'(miss_count), 32'd1);
        chk("t1_hit", 32'(hit_count), 32'd0);
        for (int k = 0; k < 4; k++) begin
            fetch(32'(k * 4), st, ins);
            chk("t2_stalls", 32'(st), 32'd0);
            chk("t2_word", ins, 32'hA5C30000 + 32'(k));
        end
        chk("t2_hit", 32'(hit_count), 32'd4);
        flush = 1'b1;
        #1 chk("t4_busy", 32'(BUSYWAIT_INSTR), 32'd1);
        @(posedge clock);
        #2 flush = 1'b0;
        fetch(32'h000, st, ins);
        chk("t4_stalls", 32'(st), 32'd6);
        chk("t4_miss", 32'(miss_count), 32'd2);
        chk("t4_hit", 32'(hit_count), 32'd4);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            fetch(t3_pc[k], st, ins);
            chk("t3_stalls", 32'(st), 32'(t3_st[k]));
        end
        chk("t3_miss", 32'(miss_count), 32'd4);
        chk("t3_hit", 32'(hit_count), 32'd2);
        PC = 32'h200;
        repeat (3) @(posedge clock);
        #2 flush = 1'b1;
        @(posedge clock);
        #2 flush = 1'b0;
        fetch(32'h200, st, ins);
        chk("t5_word", ins, 32'hA5C30080);
        chk("t5_miss", 32'(miss_count), 32'd6);
        chk("t5_hit", 32'(hit_count), 32'd2);
        fetch(32'h000, st, ins);
        chk("t5_refetch_stalls", 32'(st), 32'd6);
        PC = 32'h300;
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("t6_read", 32'(instr_read), 32'd0);
        chk("t6_busy", 32'(BUSYWAIT_INSTR), 32'd1);
        chk("t6_miss", 32'(miss_count), 32'd0);
        chk("t6_hit", 32'(hit_count), 32'd0);
        @(posedge clock);
        #2 reset = 1'b0;
        fetch(32'h300, st, ins);
        chk("t6_stalls", 32'(st), 32'd6);
        chk("t6_word", ins, 32'hA5C300C0);
        fetch(32'h000, st, ins);
        chk("t6_cold_stalls", 32'(st), 32'd6);
        chk("t6_miss_end", 32'(miss_count), 32'd2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
